// File: rtl/mux4_arb_pkg.sv
// Shared types and sizes for the 4-input round-robin arbiter.
package mux4_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Rotating-priority encoder: first eligible index at or after last+1, with wrap.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] elig,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] pick,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  // Scan from farthest to nearest so the nearest eligible index overrides.
  always_comb begin
    pick = last;
    idx  = last;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = last + IDX_W'(i);
      if (elig[idx]) pick = idx;
    end
    any = |elig;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and registered output stage for four requesters.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [N_REQ-1:0] ack,
  output logic             s0,
  output logic             s1,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] last;
  logic [N_REQ-1:0] elig_c;
  logic [IDX_W-1:0] pick_c;
  logic             any_c;
  logic             capture_c;
  logic [WIDTH-1:0] word_c;
  logic [WIDTH-1:0] next_out;
  logic [IDX_W-1:0] next_sel;
  logic [IDX_W-1:0] next_last;
  logic [N_REQ-1:0] next_ack;
  logic             next_valid;

  // A requester acked this cycle is not eligible again until next cycle.
  assign elig_c = req & ~ack;

  rr_pick4 u_pick (
    .elig (elig_c),
    .last (last),
    .pick (pick_c),
    .any  (any_c)
  );

  // Inline 4:1 word mux indexed by the current pick.
  always_comb begin
    word_c = i0;
    case (pick_c)
      2'd0:    word_c = i0;
      2'd1:    word_c = i1;
      2'd2:    word_c = i2;
      default: word_c = i3;
    endcase
  end

  // Capture when the output slot is empty or being drained this edge.
  assign capture_c = ((state == IDLE) || out_ready) && any_c;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    if (capture_c)                          next_state = HOLD;
    else if ((state == HOLD) && out_ready)  next_state = IDLE;
  end

  // Next values of the output stage.
  always_comb begin
    next_out   = out;
    next_sel   = {s1, s0};
    next_last  = last;
    next_ack   = '0;
    next_valid = (next_state == HOLD);
    if (capture_c) begin
      next_out  = word_c;
      next_sel  = pick_c;
      next_last = pick_c;
      next_ack  = N_REQ'(1) << pick_c;
    end
  end

  // Output and history registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      {s1, s0}  <= '0;
      last      <= IDX_W'(N_REQ - 1);
      ack       <= '0;
      out_valid <= 1'b0;
    end else begin
      out       <= next_out;
      {s1, s0}  <= next_sel;
      last      <= next_last;
      ack       <= next_ack;
      out_valid <= next_valid;
    end
  end

  assign busy = out_valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] i0, i1, i2, i3;
  logic [3:0] ack;
  logic       s0, s1;
  logic [3:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  mux4_rr_arbiter #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .i0        (i0),
    .i1        (i1),
    .i2        (i2),
    .i3        (i3),
    .ack       (ack),
    .s0        (s0),
    .s1        (s1),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the full visible output set.
  task automatic chk_all(input string tag, input logic [3:0] e_out, input logic [1:0] e_sel,
                         input logic [3:0] e_ack, input logic e_valid);
    chk({tag, ".out"},   8'(out),          8'(e_out));
    chk({tag, ".sel"},   8'({s1, s0}),     8'(e_sel));
    chk({tag, ".ack"},   8'(ack),          8'(e_ack));
    chk({tag, ".valid"}, 8'(out_valid),    8'(e_valid));
    chk({tag, ".busy"},  8'(busy),         8'(e_valid));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b1111; out_ready = 1'b0;
    i0 = 4'b1010; i1 = 4'b1111; i2 = 4'b0000; i3 = 4'b0101;

    // Reset held for two edges with all requests high.
    tick(); tick();
    chk_all("reset", 4'b0000, 2'b00, 4'b0000, 1'b0);

    // First grant after reset goes to requester 0.
    rst_n = 1'b1;
    tick();
    chk_all("first", 4'b1010, 2'b00, 4'b0001, 1'b1);
    req = 4'b0000; out_ready = 1'b1;
    tick();
    chk_all("first_drain", 4'b1010, 2'b00, 4'b0000, 1'b0);

    // Single request from requester 2.
    req = 4'b0100;
    tick();
    chk_all("single", 4'b0000, 2'b10, 4'b0100, 1'b1);
    req = 4'b0000;
    tick();
    chk_all("single_drain", 4'b0000, 2'b10, 4'b0000, 1'b0);

    // Reset to restore last=3, then rotate through all four.
    rst_n = 1'b0;
    tick();
    chk_all("reset2", 4'b0000, 2'b00, 4'b0000, 1'b0);
    rst_n = 1'b1; req = 4'b1111; out_ready = 1'b1;
    tick(); chk_all("rr0", 4'b1010, 2'b00, 4'b0001, 1'b1);
    tick(); chk_all("rr1", 4'b1111, 2'b01, 4'b0010, 1'b1);
    tick(); chk_all("rr2", 4'b0000, 2'b10, 4'b0100, 1'b1);
    tick(); chk_all("rr3", 4'b0101, 2'b11, 4'b1000, 1'b1);
    tick(); chk_all("rr4", 4'b1010, 2'b00, 4'b0001, 1'b1);

    // Capture i1, then stall with requester 3 pending.
    req = 4'b0010;
    tick();
    chk_all("bp_cap", 4'b1111, 2'b01, 4'b0010, 1'b1);
    req = 4'b1000; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_all($sformatf("bp_hold%0d", k), 4'b1111, 2'b01, 4'b0000, 1'b1);
    end
    out_ready = 1'b1;
    tick();
    chk_all("bp_release", 4'b0101, 2'b11, 4'b1000, 1'b1);

    // Reset in the middle of HOLD discards the held word.
    req = 4'b0000; out_ready = 1'b0;
    tick();
    chk_all("mid_hold", 4'b0101, 2'b11, 4'b0000, 1'b1);
    rst_n = 1'b0;
    tick();
    chk_all("mid_reset", 4'b0000, 2'b00, 4'b0000, 1'b0);
    rst_n = 1'b1; req = 4'b1000;
    tick();
    chk_all("post_reset", 4'b0101, 2'b11, 4'b1000, 1'b1);
    req = 4'b0000; out_ready = 1'b1;
    tick();
    chk_all("final_drain", 4'b0101, 2'b11, 4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
